// File: rtl/div16x8_seq.sv
// Sequential radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit
// per clock. Optional DIV_SELFCHECK_EN adds chk_err, a multiply-back check of each result.
module div16x8_seq #(
   parameter int unsigned DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   quot,
   output logic [DW-1:0]   rem,
   output logic            div_zero,
`ifdef DIV_SELFCHECK_EN
   output logic            ovf,
   output logic            chk_err
`else
   output logic            ovf
`endif
);

   localparam logic [DW-1:0] LastStep = DW'(DW - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e state_q, state_d;

   logic [DW-1:0] p_q, p_d;
   logic [DW-1:0] sh_q, sh_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvsr_q, dvsr_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [DW-1:0] rem_q, rem_d;
   logic          div_zero_q, div_zero_d;
   logic          ovf_q, ovf_d;

   logic          accept;
   logic          is_zero;
   logic          is_ovf;
   logic [DW:0]   p_shift;
   logic [DW-1:0] p_sub;
   logic [DW-1:0] p_step;
   logic          q_bit;

   assign accept  = in_valid && (state_q == StIdle);
   assign is_zero = (divisor == '0);
   assign is_ovf  = (dividend[2*DW-1:DW] >= divisor);

   // The stored partial remainder is always below the divisor, so DW bits hold it; only the
   // shifted value P' needs the extra bit. The subtraction is modular since its result < divisor.
   assign p_shift = {p_q, sh_q[DW-1]};
   assign q_bit   = (p_shift >= {1'b0, dvsr_q});
   assign p_sub   = p_shift[DW-1:0] - dvsr_q;
   assign p_step  = q_bit ? p_sub : p_shift[DW-1:0];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = (is_zero || is_ovf) ? StDone : StCalc;
            end
         end
         StCalc: begin
            if (cnt_q == LastStep) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   assign quot     = quot_q;
   assign rem      = rem_q;
   assign div_zero = div_zero_q;
   assign ovf      = ovf_q;

   always_comb begin
      p_d        = p_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      dvsr_d     = dvsr_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      div_zero_d = div_zero_q;
      ovf_d      = ovf_q;
      if (accept) begin
         dvsr_d     = divisor;
         p_d        = dividend[2*DW-1:DW];
         sh_d       = dividend[DW-1:0];
         cnt_d      = '0;
         quot_d     = '0;
         rem_d      = '0;
         div_zero_d = 1'b0;
         ovf_d      = 1'b0;
         if (is_zero) begin
            quot_d     = '1;
            rem_d      = dividend[DW-1:0];
            div_zero_d = 1'b1;
         end else if (is_ovf) begin
            quot_d = '1;
            ovf_d  = 1'b1;
         end
      end else if (state_q == StCalc) begin
         p_d   = p_step;
         sh_d  = {sh_q[DW-2:0], q_bit};
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LastStep) begin
            quot_d = {sh_q[DW-2:0], q_bit};
            rem_d  = p_step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q        <= '0;
         sh_q       <= '0;
         cnt_q      <= '0;
         dvsr_q     <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         p_q        <= p_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         dvsr_q     <= dvsr_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         div_zero_q <= div_zero_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef DIV_SELFCHECK_EN
   logic [2*DW-1:0] dvd_q, dvd_d;
   logic [2*DW:0]   chk_sum;

   always_comb begin
      dvd_d = dvd_q;
      if (accept) begin
         dvd_d = dividend;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q <= '0;
      end else begin
         dvd_q <= dvd_d;
      end
   end

   always_comb begin
      chk_sum = {{(DW+1){1'b0}}, quot_q} * {{(DW+1){1'b0}}, dvsr_q}
              + {{(DW+1){1'b0}}, rem_q};
      chk_err = out_valid && !div_zero_q && !ovf_q
             && ((chk_sum != {1'b0, dvd_q}) || (rem_q >= dvsr_q));
   end
`endif

endmodule
